// File: rtl/ssd_scan_counter.sv
`timescale 1ns/1ps
// N-digit BCD up/down counter with a multiplexed, active-low seven-segment scan driver.
// Each digit slot opens with a short all-off interval so the previous digit does not ghost.
module ssd_scan_counter #(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 200000,
  parameter int TICK_DIV     = 100000000,
  parameter int BLANK_CYCLES = 2000,
  parameter int LZB          = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    dir,
  input  logic                    clr,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_val,
  output logic [4*NUM_DIGITS-1:0] value,
  output logic                    wrap,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              c
);

  localparam int VW = 4 * NUM_DIGITS;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int IW = $clog2(NUM_DIGITS);

  logic [SW-1:0]         scan_cnt, scan_nxt;
  logic [TW-1:0]         tick_cnt, tick_nxt;
  logic [IW-1:0]         idx, idx_nxt;
  logic [VW-1:0]         value_nxt;
  logic [VW:0]           step_res;
  logic                  wrap_nxt, tick;
  logic [NUM_DIGITS-1:0] an_nxt;
  logic [6:0]            c_nxt;
  logic [3:0]            digit;
  logic                  lead_zero;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'b1000000;
      4'd1:    seg_decode = 7'b1111001;
      4'd2:    seg_decode = 7'b0100100;
      4'd3:    seg_decode = 7'b0110000;
      4'd4:    seg_decode = 7'b0011001;
      4'd5:    seg_decode = 7'b0010010;
      4'd6:    seg_decode = 7'b0000010;
      4'd7:    seg_decode = 7'b1111000;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0010000;
      default: seg_decode = 7'h7F;
    endcase
  endfunction

  // Ripple increment/decrement; the MSB of the result is the carry/borrow out of the top digit.
  function automatic logic [VW:0] bcd_step(input logic [VW-1:0] v, input logic up);
    logic [VW-1:0] r;
    logic [3:0]    d;
    logic          cy;
    r  = v;
    cy = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      d = r[4*k +: 4];
      if (cy) begin
        if (up) begin
          if (d == 4'd9) d = 4'd0;
          else begin d = d + 4'd1; cy = 1'b0; end
        end else begin
          if (d == 4'd0) d = 4'd9;
          else begin d = d - 4'd1; cy = 1'b0; end
        end
      end
      r[4*k +: 4] = d;
    end
    bcd_step = {cy, r};
  endfunction

  function automatic logic [VW-1:0] bcd_sat(input logic [VW-1:0] v);
    bcd_sat = v;
    for (int k = 0; k < NUM_DIGITS; k++)
      if (v[4*k +: 4] > 4'd9) bcd_sat[4*k +: 4] = 4'd9;
  endfunction

  // Scan timing runs free of the counter controls.
  always_comb begin
    scan_nxt = scan_cnt + SW'(1);
    idx_nxt  = idx;
    if (scan_cnt == SW'(SCAN_DIV - 1)) begin
      scan_nxt = '0;
      idx_nxt  = (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + IW'(1);
    end
  end

  // clr beats load beats tick; a tick that coincides with load is lost.
  always_comb begin
    tick      = en && (tick_cnt == TW'(TICK_DIV - 1));
    tick_nxt  = tick_cnt;
    value_nxt = value;
    wrap_nxt  = 1'b0;
    step_res  = bcd_step(value, dir);
    if (clr) begin
      tick_nxt  = '0;
      value_nxt = '0;
    end else begin
      if (en) tick_nxt = tick ? '0 : tick_cnt + TW'(1);
      if (load) value_nxt = bcd_sat(load_val);
      else if (tick) begin
        value_nxt = step_res[VW-1:0];
        wrap_nxt  = step_res[VW];
      end
    end
  end

  // Display is derived from next-state values so an/c line up with the registered scan position and count.
  always_comb begin
    digit     = value_nxt[{idx_nxt, 2'b00} +: 4];
    lead_zero = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++)
      if (k >= int'(idx_nxt) && value_nxt[4*k +: 4] != 4'd0) lead_zero = 1'b0;
    an_nxt = '1;
    c_nxt  = 7'h7F;
    if (scan_nxt >= SW'(BLANK_CYCLES)) begin
      an_nxt = ~(NUM_DIGITS'(1) << idx_nxt);
      c_nxt  = ((LZB != 0) && (idx_nxt != '0) && lead_zero) ? 7'h7F : seg_decode(digit);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_cnt <= '0;
      tick_cnt <= '0;
      idx      <= '0;
      value    <= '0;
      wrap     <= 1'b0;
      an       <= '1;
      c        <= 7'h7F;
    end else begin
      scan_cnt <= scan_nxt;
      tick_cnt <= tick_nxt;
      idx      <= idx_nxt;
      value    <= value_nxt;
      wrap     <= wrap_nxt;
      an       <= an_nxt;
      c        <= c_nxt;
    end
  end

endmodule

// File: tb/tb_ssd_scan_counter.sv
`timescale 1ns/1ps
// Bench for ssd_scan_counter: directed steps plus random traffic against an integer-arithmetic model
// of the count and a cycle-index model of the scan display.
module tb_ssd_scan_counter;

  localparam int ND   = 4;
  localparam int SD   = 8;
  localparam int TD   = 5;
  localparam int BL   = 2;
  localparam int MAXV = 9999;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0, dir = 1'b0, clr = 1'b0, load = 1'b0;
  logic [15:0] load_val = '0;
  logic [15:0] value;
  logic        wrap;
  logic [3:0]  an;
  logic [6:0]  c;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   m_val, m_pre, m_cyc;
  logic m_wrap;
  int   wrap_cnt;
  logic [6:0] seg_tab [10];

  always #5 clk = ~clk;

  ssd_scan_counter #(
    .NUM_DIGITS(ND), .SCAN_DIV(SD), .TICK_DIV(TD), .BLANK_CYCLES(BL), .LZB(1)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .clr(clr), .load(load),
    .load_val(load_val), .value(value), .wrap(wrap), .an(an), .c(c)
  );

  function automatic int pow10(input int k);
    int p = 1;
    for (int i = 0; i < k; i++) p = p * 10;
    return p;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r = '0;
    for (int k = 0; k < ND; k++) r[4*k +: 4] = 4'((v / pow10(k)) % 10);
    return r;
  endfunction

  function automatic int load_to_int(input logic [15:0] lv);
    int s = 0;
    int d;
    for (int k = 0; k < ND; k++) begin
      d = int'(lv[4*k +: 4]);
      if (d > 9) d = 9;
      s = s + d * pow10(k);
    end
    return s;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int pos, slot, d;
    logic [3:0] ea;
    logic [6:0] ec;
    pos  = m_cyc % SD;
    slot = (m_cyc / SD) % ND;
    ea = 4'hF;
    ec = 7'h7F;
    if (pos >= BL) begin
      ea = ~(4'(1) << slot);
      d  = (m_val / pow10(slot)) % 10;
      // digit k and everything above it are zero exactly when value < 10^k
      ec = (slot > 0 && m_val < pow10(slot)) ? 7'h7F : seg_tab[d];
    end
    check({tag, "_value"}, 32'(value), 32'(to_bcd(m_val)));
    check({tag, "_wrap"},  32'(wrap),  32'(m_wrap));
    check({tag, "_an"},    32'(an),    32'(ea));
    check({tag, "_c"},     32'(c),     32'(ec));
  endtask

  task automatic model_reset();
    m_val = 0; m_pre = 0; m_cyc = 0; m_wrap = 1'b0;
  endtask

  task automatic step(input string tag);
    logic tk;
    tk = en && (m_pre == TD - 1);
    if (clr) begin
      m_val = 0; m_pre = 0; m_wrap = 1'b0;
    end else begin
      if (en) m_pre = (m_pre + 1) % TD;
      m_wrap = 1'b0;
      if (load) m_val = load_to_int(load_val);
      else if (tk) begin
        if (dir) begin
          if (m_val == MAXV) begin m_val = 0; m_wrap = 1'b1; end
          else m_val = m_val + 1;
        end else begin
          if (m_val == 0) begin m_val = MAXV; m_wrap = 1'b1; end
          else m_val = m_val - 1;
        end
      end
    end
    m_cyc++;
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  initial begin
    seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001; seg_tab[2] = 7'b0100100;
    seg_tab[3] = 7'b0110000; seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
    seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000; seg_tab[8] = 7'b0000000;
    seg_tab[9] = 7'b0010000;
    model_reset();

    // Reset state, then release with the counter paused
    #12;
    check_all("reset");
    @(posedge clk); #1;
    rst = 1'b1;
    check_all("release");
    run("t1", 2);
    check("t1_an_digit0", 32'(an), 32'h0000000E);
    check("t1_c_digit0",  32'(c),  32'h00000040);
    run("t1", 8);
    check("t1_an_digit1", 32'(an), 32'h0000000D);
    check("t1_c_lzb",     32'(c),  32'h0000007F);

    // Count up ten ticks
    en = 1'b1; dir = 1'b1;
    run("t2", 50);
    check("t2_value_10", 32'(value), 32'h00000010);
    run("t2_scan", 32);

    // All-nines rolls over to zero with a single wrap pulse
    en = 1'b0; load = 1'b1; load_val = 16'h9999;
    step("t3_load");
    load = 1'b0; en = 1'b1; dir = 1'b1;
    wrap_cnt = 0;
    for (int i = 0; i < 2 * TD; i++) begin
      step("t3");
      if (wrap) wrap_cnt++;
    end
    check("t3_wrap_count", 32'(wrap_cnt), 32'd1);

    // Down from zero to all nines; saturating load
    en = 1'b0; clr = 1'b1;
    step("t4_clr");
    clr = 1'b0; dir = 1'b0; en = 1'b1;
    run("t4", TD);
    check("t4_value_9999", 32'(value), 32'h00009999);
    check("t4_wrap",       32'(wrap),  32'd1);
    en = 1'b0; load = 1'b1; load_val = 16'h12AF;
    step("t4_load");
    load = 1'b0;
    check("t4_sat_load", 32'(value), 32'h00001299);

    // Pause holds the prescaler; clr wins over load
    clr = 1'b1;
    step("t5_clr");
    clr = 1'b0; dir = 1'b1; en = 1'b1;
    run("t5_run", 3);
    en = 1'b0;
    run("t5_pause", 20);
    en = 1'b1;
    step("t5_resume1");
    check("t5_no_tick_yet", 32'(value), 32'h00000000);
    step("t5_resume2");
    check("t5_tick", 32'(value), 32'h00000001);
    clr = 1'b1; load = 1'b1; load_val = 16'h5555;
    step("t5_clr_load");
    clr = 1'b0; load = 1'b0;
    check("t5_clr_wins", 32'(value), 32'h00000000);

    // Asynchronous reset in the middle of a lit slot
    en = 1'b0; load = 1'b1; load_val = 16'h0042;
    step("t6_load");
    load = 1'b0;
    for (int i = 0; i < 2 * SD && an == 4'hF; i++) step("t6_wait");
    check("t6_lit", 32'(an != 4'hF), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("t6_rst_value", 32'(value), 32'd0);
    check("t6_rst_wrap",  32'(wrap),  32'd0);
    check("t6_rst_an",    32'(an),    32'h0000000F);
    check("t6_rst_c",     32'(c),     32'h0000007F);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    check_all("t6_release");
    run("t6_after", 12);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      en   = ($urandom_range(0, 3) != 0);
      dir  = 1'($urandom_range(0, 1));
      clr  = ($urandom_range(0, 40) == 0);
      load = ($urandom_range(0, 25) == 0);
      case ($urandom_range(0, 3))
        0:       load_val = 16'h9999;
        1:       load_val = 16'h0000;
        default: load_val = 16'($urandom);
      endcase
      step("rand");
    end
    clr = 1'b0; load = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
